// File: rtl/sprite_blitter.sv
// sprite_blitter: streams an anchored, optionally mirrored sprite from a synchronous ROM
// as one clipped, transparency-filtered plot slot per texel.
module sprite_blitter #(
    parameter int SPR_W_LOG2  = 3,
    parameter int SPR_H_LOG2  = 3,
    parameter int X_WIDTH     = 8,
    parameter int Y_WIDTH     = 7,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int ID_WIDTH    = 4,
    parameter int PIX_WIDTH   = 4,
    parameter int TRANSPARENT = 0,
    localparam int ADDR_W     = ID_WIDTH + SPR_H_LOG2 + SPR_W_LOG2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [X_WIDTH-1:0]   x_in,
    input  logic [Y_WIDTH-1:0]   y_in,
    input  logic [ID_WIDTH-1:0]  sprite_id_in,
    input  logic                 flip_h_in,
    input  logic                 flip_v_in,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PIX_WIDTH-1:0] rom_data,
    output logic                 plot,
    output logic [X_WIDTH-1:0]   x_out,
    output logic [Y_WIDTH-1:0]   y_out,
    output logic [PIX_WIDTH-1:0] pix_out
);
    localparam int CW = SPR_W_LOG2 + SPR_H_LOG2;

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         c;
    logic [X_WIDTH-1:0]    xa;
    logic [Y_WIDTH-1:0]    ya;
    logic [ID_WIDTH-1:0]   id;
    logic                  fh, fv;
    logic [SPR_W_LOG2-1:0] px, sx, px_q;
    logic [SPR_H_LOG2-1:0] py, sy, py_q;
    logic                  v_q, done_q;
    logic [X_WIDTH:0]      sum_x;
    logic [Y_WIDTH:0]      sum_y;

    assign px = c[SPR_W_LOG2-1:0];
    assign py = c[CW-1:SPR_W_LOG2];
    // Sprite dimensions are powers of two, so W-1-px is just the bitwise complement.
    assign sx = fh ? ~px : px;
    assign sy = fv ? ~py : py;
    assign sum_x = (X_WIDTH+1)'(xa) + (X_WIDTH+1)'(px_q);
    assign sum_y = (Y_WIDTH+1)'(ya) + (Y_WIDTH+1)'(py_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            c      <= '0;
            xa     <= '0;
            ya     <= '0;
            id     <= '0;
            fh     <= 1'b0;
            fv     <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= state == LAST;
            v_q    <= state == RUN;
            px_q   <= px;
            py_q   <= py;
            c      <= (state == RUN) ? c + CW'(1) : '0;
            if (state == IDLE && start) begin
                xa <= x_in;
                ya <= y_in;
                id <= sprite_id_in;
                fh <= flip_h_in;
                fv <= flip_v_in;
            end
        end
    end

    always_comb begin
        state_n  = (state == IDLE && start) ? RUN :
                   (state == RUN && &c)     ? LAST :
                   (state == LAST)          ? IDLE : state;
        busy     = state != IDLE;
        done     = done_q;
        rom_addr = (state == RUN) ? {id, sy, sx} : '0;
        // v_q marks that rom_data belongs to the texel whose coordinates sit in px_q/py_q.
        plot     = v_q && rom_data != PIX_WIDTH'(TRANSPARENT) &&
                   int'(sum_x) < SCREEN_W && int'(sum_y) < SCREEN_H;
        x_out    = plot ? sum_x[X_WIDTH-1:0] : '0;
        y_out    = plot ? sum_y[Y_WIDTH-1:0] : '0;
        pix_out  = plot ? rom_data : '0;
    end
endmodule
